alu_share_ctrl: RTL

//   Shares the single combinational 32-bit ALU between two requesters (req0 = execute stage,
//   req1 = branch/compare unit) using round-robin arbitration. Registers the granted op/operands,

---
 rtl/alu_share_if.sv | 44 ++++
 rtl/alu_share_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_share_if.sv
// Bundle between the two ALU requesters, the shared ALU and the response consumer.
// The slave side belongs to the controller; the master side belongs to requesters, the ALU and the consumer.
interface alu_share_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_wen;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_wen
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_wen
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Arbitrates one combinational ALU between two requesters and returns the result
// tagged with the owner's ID, plus the MOVN/MOVZ write-enable.
module alu_share_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned OP_W       = 6,
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_share_if.slave  bus
);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] OP_MOVN = OP_W'(6'b001011);
  localparam logic [OP_W-1:0] OP_MOVZ = OP_W'(6'b001010);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              pend_id_q, pend_id_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_wen_q, rsp_wen_d;

  logic can_accept;
  logic grant1;
  logic accept;
  logic move_fail;

  // Arbitration: a lone requester always wins; ties go by policy.
  always_comb begin
    can_accept = (state_q == IDLE) | ((state_q == HOLD) & bus.rsp_ready);
    if (bus.req0_valid & bus.req1_valid) begin
      grant1 = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      grant1 = bus.req1_valid;
    end
    accept         = can_accept & (bus.req0_valid | bus.req1_valid);
    bus.req0_ready = accept & ~grant1;
    bus.req1_ready = accept & grant1;
    move_fail = ((alu_op_q == OP_MOVN) & (alu_b_q == '0)) |
                ((alu_op_q == OP_MOVZ) & (alu_b_q != '0));
  end

  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    pend_id_d    = pend_id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_wen_d    = rsp_wen_q;

    unique case (state_q)
      IDLE, HOLD: begin
        if (state_q == HOLD && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
        if (accept) begin
          alu_op_d     = grant1 ? bus.req1_op : bus.req0_op;
          alu_a_d      = grant1 ? bus.req1_a  : bus.req0_a;
          alu_b_d      = grant1 ? bus.req1_b  : bus.req0_b;
          pend_id_d    = grant1;
          last_grant_d = grant1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d  = bus.alu_result;
        rsp_id_d    = pend_id_q;
        rsp_valid_d = 1'b1;
        rsp_wen_d   = ~move_fail;
        state_d     = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      alu_op_q     <= OP_AND;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      pend_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_wen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      pend_id_q    <= pend_id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_wen_q    <= rsp_wen_d;
    end
  end

  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_wen   = rsp_wen_q;
endmodule
